// File: rtl/spinner_pkg.sv
// Shared types and helpers for the multi-channel spinner/paddle angle block.
// Provides the button-direction enum, counter-width helpers and the clamp-mode saturating add.
// Contains no ports; imported by spinner_channel and spinner_array.
package spinner_pkg;

    // Button direction seen on a strobe edge; DIR_NONE covers "neither" and "both".
    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_MINUS = 2'd1,
        DIR_PLUS  = 2'd2
    } dir_t;

    // Bits needed to hold a multiplier value in 1..max_mult.
    function automatic int mult_width(input int max_mult);
        return (max_mult < 2) ? 1 : $clog2(max_mult + 1);
    endfunction

    // Bits needed for the hold counter, which saturates at accel_frames*(max_mult-1).
    function automatic int hold_width(input int accel_frames, input int max_mult);
        int hold_max;
        hold_max = accel_frames * (max_mult - 1);
        return (hold_max < 2) ? 1 : $clog2(hold_max + 1);
    endfunction

    // Clamp-mode update: acc + delta saturated to [0, 2^acc_w - 1].
    // The sum only ever needs acc_w+2 bits (sign plus one overflow bit),
    // which a 64-bit intermediate covers for any practical accumulator width.
    function automatic int sat_add(input int acc, input int delta, input int acc_w);
        longint sum;
        longint top;
        sum = longint'(acc) + longint'(delta);
        top = (longint'(1) << acc_w) - longint'(1);
        if (sum < 0)
            return 0;
        else if (sum > top)
            return int'(top);
        else
            return int'(sum);
    endfunction

endpackage

// File: rtl/spinner_channel.sv
// One angle accumulator: button stepping with hold acceleration, spinner pulse stepping, wrap or clamp.
// Ports: clk/reset, strobe_edge (single-cycle), per-channel controls in, angle/moved out.
// Angle reflects an event one cycle after it is sampled; moved pulses in the same cycle the new angle appears.
module spinner_channel
    import spinner_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               FRAC_BITS    = 4,
    parameter int               STEP         = 55,
    parameter int               ACCEL_FRAMES = 8,
    parameter int               MAX_MULT     = 4,
    parameter logic [WIDTH-1:0] INIT         = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             strobe_edge,
    input  logic             mode_clamp,
    input  logic             minus,
    input  logic             plus,
    input  logic             pulse_ccw,
    input  logic             pulse_cw,
    input  logic             center,
    output logic [WIDTH-1:0] angle,
    output logic             moved
);

    localparam int ACC_W    = WIDTH + FRAC_BITS;
    localparam int HOLD_W   = hold_width(ACCEL_FRAMES, MAX_MULT);
    localparam int MULT_W   = mult_width(MAX_MULT);
    localparam int PULSE_SZ = 1 << FRAC_BITS;

    localparam logic [ACC_W-1:0]  ACC_INIT = ACC_W'(INIT) << FRAC_BITS;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(ACCEL_FRAMES * (MAX_MULT - 1));

    logic [ACC_W-1:0]  acc;
    logic [HOLD_W-1:0] hold;
    dir_t              last_dir;
    logic              cw_d;
    logic              ccw_d;

    logic [ACC_W-1:0]  acc_n;
    logic [HOLD_W-1:0] hold_n;
    dir_t              dir_n;
    dir_t              btn_dir;
    logic [MULT_W-1:0] mult;
    logic              cw_edge;
    logic              ccw_edge;
    logic              moved_n;
    int                hold_div;
    int                delta;

    assign cw_edge  = pulse_cw  & ~cw_d;
    assign ccw_edge = pulse_ccw & ~ccw_d;

    always_comb begin
        btn_dir = DIR_NONE;
        if (plus && !minus)
            btn_dir = DIR_PLUS;
        else if (minus && !plus)
            btn_dir = DIR_MINUS;
    end

    // Multiplier is taken from hold as it stands before this strobe updates it.
    always_comb begin
        hold_div = int'(hold) / ACCEL_FRAMES;
        if (hold_div > MAX_MULT - 1)
            hold_div = MAX_MULT - 1;
        mult = MULT_W'(hold_div + 1);
    end

    always_comb begin
        hold_n = hold;
        dir_n  = last_dir;
        delta  = 0;

        if (strobe_edge) begin
            if (btn_dir == DIR_NONE) begin
                hold_n = '0;
                dir_n  = DIR_NONE;
            end else begin
                // A fresh press (from NONE or the opposite direction) restarts at hold=1,
                // so the following strobe in that direction still runs at mult 1.
                if (btn_dir == last_dir)
                    hold_n = (hold == HOLD_MAX) ? hold : hold + HOLD_W'(1);
                else
                    hold_n = HOLD_W'(1);
                dir_n = btn_dir;
                if (btn_dir == DIR_PLUS)
                    delta = STEP * int'(mult);
                else
                    delta = -(STEP * int'(mult));
            end
        end

        // Opposite pulse edges in one cycle cancel naturally in the sum.
        if (cw_edge)
            delta = delta + PULSE_SZ;
        if (ccw_edge)
            delta = delta - PULSE_SZ;
    end

    always_comb begin
        if (mode_clamp)
            acc_n = ACC_W'(sat_add(int'(acc), delta, ACC_W));
        else
            acc_n = ACC_W'(int'(acc) + delta);

        if (center)
            moved_n = (acc[ACC_W-1:FRAC_BITS] != INIT);
        else
            moved_n = (acc_n[ACC_W-1:FRAC_BITS] != acc[ACC_W-1:FRAC_BITS]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= ACC_INIT;
            hold     <= '0;
            last_dir <= DIR_NONE;
            cw_d     <= 1'b0;
            ccw_d    <= 1'b0;
            moved    <= 1'b0;
        end else begin
            // Edge registers follow their inputs even under center so release is glitch-free.
            cw_d  <= pulse_cw;
            ccw_d <= pulse_ccw;
            moved <= moved_n;
            if (center) begin
                acc      <= ACC_INIT;
                hold     <= '0;
                last_dir <= DIR_NONE;
            end else begin
                acc      <= acc_n;
                hold     <= hold_n;
                last_dir <= dir_n;
            end
        end
    end

    assign angle = acc[ACC_W-1:FRAC_BITS];

endmodule

// File: rtl/spinner_array.sv
// CHANNELS independent spinner/paddle angle accumulators sharing one frame strobe.
// Ports: clk/reset, strobe, per-channel mode_clamp/minus/plus/pulse_ccw/pulse_cw/center in; flat angle, moved out.
// Strobe rising edge is detected once here and handed to every channel as a single-cycle pulse.
module spinner_array
    import spinner_pkg::*;
#(
    parameter int               CHANNELS     = 2,
    parameter int               WIDTH        = 8,
    parameter int               FRAC_BITS    = 4,
    parameter int               STEP         = 55,
    parameter int               ACCEL_FRAMES = 8,
    parameter int               MAX_MULT     = 4,
    parameter logic [WIDTH-1:0] INIT         = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      strobe,
    input  logic [CHANNELS-1:0]       mode_clamp,
    input  logic [CHANNELS-1:0]       minus,
    input  logic [CHANNELS-1:0]       plus,
    input  logic [CHANNELS-1:0]       pulse_ccw,
    input  logic [CHANNELS-1:0]       pulse_cw,
    input  logic [CHANNELS-1:0]       center,
    output logic [CHANNELS*WIDTH-1:0] angle,
    output logic [CHANNELS-1:0]       moved
);

    logic strobe_d;
    logic strobe_edge;

    always_ff @(posedge clk) begin
        if (reset)
            strobe_d <= 1'b0;
        else
            strobe_d <= strobe;
    end

    assign strobe_edge = strobe & ~strobe_d;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        spinner_channel #(
            .WIDTH        (WIDTH),
            .FRAC_BITS    (FRAC_BITS),
            .STEP         (STEP),
            .ACCEL_FRAMES (ACCEL_FRAMES),
            .MAX_MULT     (MAX_MULT),
            .INIT         (INIT)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .strobe_edge (strobe_edge),
            .mode_clamp  (mode_clamp[k]),
            .minus       (minus[k]),
            .plus        (plus[k]),
            .pulse_ccw   (pulse_ccw[k]),
            .pulse_cw    (pulse_cw[k]),
            .center      (center[k]),
            .angle       (angle[k*WIDTH +: WIDTH]),
            .moved       (moved[k])
        );
    end

endmodule
